// File: rtl/mem_access_ctrl_if.sv
// Load/store request, response and data-memory signals for mem_access_ctrl.
//   slave  : controller view (accepts requests, drives the memory enables)
//   master : pipeline/memory view (issues requests, supplies READ_DATA)
// Signals:
//   REQ_VALID/READY/WRITE/SIZE/SIGNED/ADDR/WDATA  request handshake and fields
//   RESP_VALID/ERR/RDATA                          completion pulse, error, load data
//   MEM_READ/MEM_WRITE/ADRESS/WRITE_DATA          registered memory controls
//   READ_DATA                                     combinational memory read data
interface mem_access_ctrl_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [1:0]  REQ_SIZE;
    logic        REQ_SIGNED;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RESP_VALID;
    logic        RESP_ERR;
    logic [31:0] RESP_RDATA;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] ADRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;

    modport slave (
        input  REQ_VALID, REQ_WRITE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA, READ_DATA,
        output REQ_READY, RESP_VALID, RESP_ERR, RESP_RDATA,
        output MEM_READ, MEM_WRITE, ADRESS, WRITE_DATA
    );

    modport master (
        output REQ_VALID, REQ_WRITE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA, READ_DATA,
        input  REQ_READY, RESP_VALID, RESP_ERR, RESP_RDATA,
        input  MEM_READ, MEM_WRITE, ADRESS, WRITE_DATA
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a word-only, level-sensitive data memory.
// Handles byte/halfword extension on loads and read-modify-write for
// sub-word stores. All memory-side outputs come straight from flops.
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous active-high reset
//   bus  mem_access_ctrl_if.slave (request, response and memory signals)
module mem_access_ctrl #(
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic               CLK,
    input  logic               RST,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]  state_q,      state_d;
    logic        mem_read_q,   mem_read_d;
    logic        mem_write_q,  mem_write_d;
    logic [31:0] adress_q,     adress_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q,   resp_err_d;
    logic [31:0] rdata_q,      rdata_d;
    logic        write_q,      write_d;
    logic [1:0]  size_q,       size_d;
    logic        signed_q,     signed_d;
    logic [1:0]  lane_q,       lane_d;
    logic [15:0] st_data_q,    st_data_d;

    logic        req_err_c;
    logic [7:0]  rd_byte_c;
    logic [15:0] rd_half_c;
    logic [31:0] load_ext_c;
    logic [31:0] merge_c;

    assign bus.REQ_READY  = (state_q == IDLE) & ~RST;
    assign bus.MEM_READ   = mem_read_q;
    assign bus.MEM_WRITE  = mem_write_q;
    assign bus.ADRESS     = adress_q;
    assign bus.WRITE_DATA = wdata_q;
    assign bus.RESP_VALID = resp_valid_q;
    assign bus.RESP_ERR   = resp_err_q;
    assign bus.RESP_RDATA = rdata_q;

    // Reject illegal size, misalignment and addresses beyond the memory.
    always_comb begin
        req_err_c = 1'b0;
        if (bus.REQ_SIZE == 2'b11)
            req_err_c = 1'b1;
        if ((bus.REQ_SIZE == SZ_HALF) && bus.REQ_ADDR[0])
            req_err_c = 1'b1;
        if ((bus.REQ_SIZE == SZ_WORD) && (bus.REQ_ADDR[1:0] != 2'b00))
            req_err_c = 1'b1;
        if ((bus.REQ_ADDR >> (ADDR_BITS + 2)) != 32'd0)
            req_err_c = 1'b1;
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    always_comb begin
        rd_byte_c = bus.READ_DATA[7:0];
        case (lane_q)
            2'd1:    rd_byte_c = bus.READ_DATA[15:8];
            2'd2:    rd_byte_c = bus.READ_DATA[23:16];
            2'd3:    rd_byte_c = bus.READ_DATA[31:24];
            default: rd_byte_c = bus.READ_DATA[7:0];
        endcase
        rd_half_c = lane_q[1] ? bus.READ_DATA[31:16] : bus.READ_DATA[15:0];

        load_ext_c = bus.READ_DATA;
        case (size_q)
            SZ_BYTE: load_ext_c = signed_q ? {{24{rd_byte_c[7]}}, rd_byte_c}
                                           : {24'h000000, rd_byte_c};
            SZ_HALF: load_ext_c = signed_q ? {{16{rd_half_c[15]}}, rd_half_c}
                                           : {16'h0000, rd_half_c};
            default: load_ext_c = bus.READ_DATA;
        endcase

        merge_c = bus.READ_DATA;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'd1:    merge_c[15:8]  = st_data_q[7:0];
                2'd2:    merge_c[23:16] = st_data_q[7:0];
                2'd3:    merge_c[31:24] = st_data_q[7:0];
                default: merge_c[7:0]   = st_data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merge_c[31:16] = st_data_q;
        end else begin
            merge_c[15:0] = st_data_q;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        adress_d     = adress_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        st_data_d    = st_data_q;

        case (state_q)
            IDLE: begin
                if (bus.REQ_VALID) begin
                    write_d   = bus.REQ_WRITE;
                    size_d    = bus.REQ_SIZE;
                    signed_d  = bus.REQ_SIGNED;
                    lane_d    = bus.REQ_ADDR[1:0];
                    st_data_d = bus.REQ_WDATA[15:0];
                    if (req_err_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.REQ_WRITE && (bus.REQ_SIZE == SZ_WORD)) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        adress_d    = 32'(bus.REQ_ADDR[ADDR_BITS+1:2]);
                        wdata_d     = bus.REQ_WDATA;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d    = RD;
                        mem_read_d = 1'b1;
                        adress_d   = 32'(bus.REQ_ADDR[ADDR_BITS+1:2]);
                    end
                end
            end
            RD: begin
                if (write_q) begin
                    state_d     = WR;
                    mem_write_d = 1'b1;
                    wdata_d     = merge_c;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = load_ext_c;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            adress_q     <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            st_data_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            adress_q     <= adress_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            st_data_q    <= st_data_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 32-word level-sensitive memory model.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   rd_cnt   = 0;
    int   wr_cnt   = 0;
    int   resp_cnt = 0;
    logic [31:0] mem [32];

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.ADDR_BITS(5)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.READ_DATA = mem[bus.ADRESS[4:0]];

    always @(posedge clk) begin
        if (bus.MEM_WRITE === 1'b1) mem[bus.ADRESS[4:0]] <= bus.WRITE_DATA;
        if (bus.MEM_READ === 1'b1)   rd_cnt++;
        if (bus.MEM_WRITE === 1'b1)  wr_cnt++;
        if (bus.RESP_VALID === 1'b1) resp_cnt++;
    end

    // Present a request on a falling edge; return #1 into cycle N+1.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.REQ_VALID  = 1'b1;
        bus.REQ_WRITE  = w;
        bus.REQ_SIZE   = sz;
        bus.REQ_SIGNED = sg;
        bus.REQ_ADDR   = addr;
        bus.REQ_WDATA  = wd;
        @(posedge clk); #1;
        bus.REQ_VALID  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.REQ_VALID = 1'b1; bus.REQ_WRITE = 1'b1; bus.REQ_SIZE = 2'b10;
        bus.REQ_SIGNED = 1'b0; bus.REQ_ADDR = 32'h0C; bus.REQ_WDATA = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.REQ_READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.REQ_READY); end
            checks++; if ({bus.MEM_READ, bus.MEM_WRITE, bus.RESP_VALID, bus.RESP_ERR} !== 4'b0000) begin
                failures++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.MEM_READ, bus.MEM_WRITE, bus.RESP_VALID, bus.RESP_ERR}); end
            checks++; if ({bus.ADRESS, bus.WRITE_DATA, bus.RESP_RDATA} !== 96'd0) begin
                failures++; $display("FAIL reset_data got=%h %h %h exp=0", bus.ADRESS, bus.WRITE_DATA, bus.RESP_RDATA); end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.REQ_VALID = 1'b0;
        #1;
        checks++; if (bus.REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.REQ_READY); end
        checks++; if (wr_cnt !== 0 || rd_cnt !== 0) begin failures++; $display("FAIL reset_no_access rd=%0d wr=%0d exp=0", rd_cnt, wr_cnt); end
    endtask

    task automatic test_word_store();
        issue(1'b1, 2'b10, 1'b0, 32'h0000000C, 32'h8899AABB);
        checks++; if (bus.MEM_WRITE !== 1'b1 || bus.MEM_READ !== 1'b0) begin
            failures++; $display("FAIL sw_enables got rd=%b wr=%b exp rd=0 wr=1", bus.MEM_READ, bus.MEM_WRITE); end
        checks++; if (bus.ADRESS !== 32'd3) begin failures++; $display("FAIL sw_adress got=%h exp=3", bus.ADRESS); end
        checks++; if (bus.WRITE_DATA !== 32'h8899AABB) begin failures++; $display("FAIL sw_wdata got=%h exp=8899aabb", bus.WRITE_DATA); end
        checks++; if (bus.REQ_READY !== 1'b0) begin failures++; $display("FAIL sw_ready_wr got=%b exp=0", bus.REQ_READY); end
        @(posedge clk); #1;
        checks++; if (bus.RESP_VALID !== 1'b1 || bus.RESP_ERR !== 1'b0 || bus.MEM_WRITE !== 1'b0) begin
            failures++; $display("FAIL sw_resp got v=%b e=%b wr=%b exp v=1 e=0 wr=0", bus.RESP_VALID, bus.RESP_ERR, bus.MEM_WRITE); end
        checks++; if (bus.REQ_READY !== 1'b0) begin failures++; $display("FAIL sw_ready_resp got=%b exp=0", bus.REQ_READY); end
        @(posedge clk); #1;
        checks++; if (bus.RESP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1) begin
            failures++; $display("FAIL sw_idle got v=%b rdy=%b exp v=0 rdy=1", bus.RESP_VALID, bus.REQ_READY); end
    endtask

    task automatic test_sub_loads();
        logic [31:0] addr [5] = '{32'h0D, 32'h0F, 32'h0E, 32'h0C, 32'h0C};
        logic [1:0]  sz   [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        sg   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp  [5] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, sz[i], sg[i], addr[i], 32'hFFFFFFFF);
            checks++; if (bus.MEM_READ !== 1'b1 || bus.MEM_WRITE !== 1'b0 || bus.ADRESS !== 32'd3) begin
                failures++; $display("FAIL load%0d_rd got rd=%b wr=%b adr=%h exp rd=1 wr=0 adr=3", i, bus.MEM_READ, bus.MEM_WRITE, bus.ADRESS); end
            @(posedge clk); #1;
            checks++; if (bus.RESP_VALID !== 1'b1 || bus.RESP_ERR !== 1'b0 || bus.RESP_RDATA !== exp[i]) begin
                failures++; $display("FAIL load%0d_resp got v=%b e=%b d=%h exp v=1 e=0 d=%h", i, bus.RESP_VALID, bus.RESP_ERR, bus.RESP_RDATA, exp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_byte_store();
        int wr0;
        wr0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h0000000E, 32'h12345677);
        checks++; if (bus.MEM_READ !== 1'b1 || bus.MEM_WRITE !== 1'b0 || bus.ADRESS !== 32'd3) begin
            failures++; $display("FAIL sb_rd got rd=%b wr=%b adr=%h exp rd=1 wr=0 adr=3", bus.MEM_READ, bus.MEM_WRITE, bus.ADRESS); end
        @(posedge clk); #1;
        checks++; if (bus.MEM_WRITE !== 1'b1 || bus.MEM_READ !== 1'b0 || bus.WRITE_DATA !== 32'h8877AABB) begin
            failures++; $display("FAIL sb_wr got rd=%b wr=%b wd=%h exp rd=0 wr=1 wd=8877aabb", bus.MEM_READ, bus.MEM_WRITE, bus.WRITE_DATA); end
        @(posedge clk); #1;
        checks++; if (bus.RESP_VALID !== 1'b1 || bus.RESP_ERR !== 1'b0 || bus.MEM_WRITE !== 1'b0) begin
            failures++; $display("FAIL sb_resp got v=%b e=%b wr=%b exp v=1 e=0 wr=0", bus.RESP_VALID, bus.RESP_ERR, bus.MEM_WRITE); end
        checks++; if (wr_cnt - wr0 !== 1) begin failures++; $display("FAIL sb_write_count got=%0d exp=1", wr_cnt - wr0); end
        @(posedge clk); #1;
        issue(1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0);
        @(posedge clk); #1;
        checks++; if (bus.RESP_VALID !== 1'b1 || bus.RESP_RDATA !== 32'h8877AABB) begin
            failures++; $display("FAIL sb_readback got v=%b d=%h exp v=1 d=8877aabb", bus.RESP_VALID, bus.RESP_RDATA); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic [31:0] addr [5] = '{32'h0E, 32'h0D, 32'h80, 32'h0C, 32'h4000000C};
        logic [1:0]  sz   [5] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b00};
        logic        w    [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int rd0, wr0;
        for (int i = 0; i < 5; i++) begin
            rd0 = rd_cnt; wr0 = wr_cnt;
            issue(w[i], sz[i], 1'b1, addr[i], 32'h55555555);
            checks++; if (bus.RESP_VALID !== 1'b1 || bus.RESP_ERR !== 1'b1) begin
                failures++; $display("FAIL err%0d_resp got v=%b e=%b exp v=1 e=1", i, bus.RESP_VALID, bus.RESP_ERR); end
            checks++; if (bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0) begin
                failures++; $display("FAIL err%0d_enables got rd=%b wr=%b exp 0 0", i, bus.MEM_READ, bus.MEM_WRITE); end
            checks++; if (bus.RESP_RDATA !== 32'h8877AABB) begin
                failures++; $display("FAIL err%0d_rdata got=%h exp=8877aabb", i, bus.RESP_RDATA); end
            @(posedge clk); #1;
            checks++; if (bus.RESP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1 || rd_cnt != rd0 || wr_cnt != wr0) begin
                failures++; $display("FAIL err%0d_after got v=%b rdy=%b drd=%0d dwr=%0d exp v=0 rdy=1 0 0", i, bus.RESP_VALID, bus.REQ_READY, rd_cnt - rd0, wr_cnt - wr0); end
        end
    endtask

    // A request held valid through RESP is only taken once the controller is back in IDLE.
    task automatic test_back_to_back();
        @(negedge clk);
        bus.REQ_VALID = 1'b1; bus.REQ_WRITE = 1'b0; bus.REQ_SIZE = 2'b00;
        bus.REQ_SIGNED = 1'b0; bus.REQ_ADDR = 32'h0C; bus.REQ_WDATA = 32'h0;
        @(posedge clk); #1;
        bus.REQ_ADDR = 32'h0D;
        checks++; if (bus.MEM_READ !== 1'b1) begin failures++; $display("FAIL b2b_rd1 got=%b exp=1", bus.MEM_READ); end
        @(posedge clk); #1;
        checks++; if (bus.RESP_VALID !== 1'b1 || bus.RESP_RDATA !== 32'h000000BB || bus.REQ_READY !== 1'b0) begin
            failures++; $display("FAIL b2b_resp1 got v=%b d=%h rdy=%b exp v=1 d=000000bb rdy=0", bus.RESP_VALID, bus.RESP_RDATA, bus.REQ_READY); end
        @(posedge clk); #1;
        checks++; if (bus.MEM_READ !== 1'b0 || bus.RESP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1) begin
            failures++; $display("FAIL b2b_idle got rd=%b v=%b rdy=%b exp rd=0 v=0 rdy=1", bus.MEM_READ, bus.RESP_VALID, bus.REQ_READY); end
        @(posedge clk); #1;
        bus.REQ_VALID = 1'b0;
        checks++; if (bus.MEM_READ !== 1'b1 || bus.ADRESS !== 32'd3) begin
            failures++; $display("FAIL b2b_rd2 got rd=%b adr=%h exp rd=1 adr=3", bus.MEM_READ, bus.ADRESS); end
        @(posedge clk); #1;
        checks++; if (bus.RESP_VALID !== 1'b1 || bus.RESP_RDATA !== 32'h000000AA) begin
            failures++; $display("FAIL b2b_resp2 got v=%b d=%h exp v=1 d=000000aa", bus.RESP_VALID, bus.RESP_RDATA); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int wr0, resp0;
        wr0 = wr_cnt; resp0 = resp_cnt;
        issue(1'b1, 2'b01, 1'b0, 32'h0000000C, 32'h0000CAFE);
        checks++; if (bus.MEM_READ !== 1'b1) begin failures++; $display("FAIL rmid_rd got=%b exp=1", bus.MEM_READ); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.MEM_WRITE !== 1'b0 || bus.RESP_VALID !== 1'b0 || bus.REQ_READY !== 1'b0) begin
            failures++; $display("FAIL rmid_reset got wr=%b v=%b rdy=%b exp 0 0 0", bus.MEM_WRITE, bus.RESP_VALID, bus.REQ_READY); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_cnt != wr0 || resp_cnt != resp0) begin
            failures++; $display("FAIL rmid_no_effect got dwr=%0d dresp=%0d exp 0 0", wr_cnt - wr0, resp_cnt - resp0); end
        issue(1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0);
        @(posedge clk); #1;
        checks++; if (bus.RESP_VALID !== 1'b1 || bus.RESP_RDATA !== 32'h8877AABB) begin
            failures++; $display("FAIL rmid_readback got v=%b d=%h exp v=1 d=8877aabb", bus.RESP_VALID, bus.RESP_RDATA); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        test_reset();
        test_word_store();
        test_sub_loads();
        test_byte_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
